xbar_cell_writer: RTL and testbench

//  Programming-side counterpart of the crossbar evaluation netlist: drives write pulses

---
 rtl/xbar_cell_writer.sv | 159 +++++++++++++++
 tb/tb_xbar_cell_writer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/xbar_cell_writer.sv
// Write-pulse sequencer for a ROWS x COLS memristive crossbar: one cell command per
// handshake, sequenced settle -> pulse -> hold, with a shadow map of programmed states.
module xbar_cell_writer #(
    parameter int ROWS       = 2,
    parameter int COLS       = 4,
    parameter int SETTLE_CYC = 2,
    parameter int PULSE_CYC  = 4,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [RW-1:0]        cmd_row,
    input  logic [CW-1:0]        cmd_col,
    input  logic                 cmd_set,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_sel,
    output logic                 wr_pol,
    output logic                 wr_en,
    output logic                 done,
    output logic                 err,
    output logic [ROWS*COLS-1:0] cfg_state,
    output logic [ROWS*COLS-1:0] cfg_known
);
    localparam int NCELL = ROWS * COLS;
    localparam int CMAX  = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int CNTW  = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              pol_q, pol_d;
    logic [ROWS-1:0]   row_sel_q, row_sel_d;
    logic [COLS-1:0]   col_sel_q, col_sel_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [NCELL-1:0]  cfg_state_q, cfg_state_d;
    logic [NCELL-1:0]  cfg_known_q, cfg_known_d;
    logic [NCELL-1:0]  cell_mask;
    logic              accept;
    logic              range_bad;
    logic              sel_active;

    // Cell bit r*COLS+c of the latched target.
    for (genvar gi = 0; gi < NCELL; gi++) begin : g_mask
        assign cell_mask[gi] = (int'(row_q) == gi / COLS) && (int'(col_q) == gi % COLS);
    end

    assign accept    = cmd_valid && (state_q == IDLE);
    assign range_bad = (int'(cmd_row) >= ROWS) || (int'(cmd_col) >= COLS);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        pol_d       = pol_q;
        err_d       = 1'b0;
        cfg_state_d = cfg_state_q;
        cfg_known_d = cfg_known_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        row_d   = cmd_row;
                        col_d   = cmd_col;
                        pol_d   = cmd_set;
                        state_d = SETUP;
                        cnt_d   = CNTW'(SETTLE_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = CNTW'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CNTW'(SETTLE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    cfg_state_d = (cfg_state_q & ~cell_mask) | (pol_q ? cell_mask : '0);
                    cfg_known_d = cfg_known_q | cell_mask;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Driver outputs are registered from the next state so they align with the state register.
    always_comb begin
        sel_active = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
        row_sel_d  = sel_active ? (ROWS'(1) << row_d) : '0;
        col_sel_d  = sel_active ? (COLS'(1) << col_d) : '0;
        wr_en_d    = (state_d == PULSE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pol_q       <= 1'b0;
            row_sel_q   <= '0;
            col_sel_q   <= '0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cfg_state_q <= '0;
            cfg_known_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pol_q       <= pol_d;
            row_sel_q   <= row_sel_d;
            col_sel_q   <= col_sel_d;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cfg_state_q <= cfg_state_d;
            cfg_known_q <= cfg_known_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign row_sel   = row_sel_q;
    assign col_sel   = col_sel_q;
    assign wr_pol    = pol_q;
    assign wr_en     = wr_en_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cfg_state = cfg_state_q;
    assign cfg_known = cfg_known_q;
endmodule

// File: tb/tb_xbar_cell_writer.sv
// Directed bench for xbar_cell_writer with ROWS=3, COLS=4, SETTLE_CYC=2, PULSE_CYC=4.
module tb_xbar_cell_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_row = '0;
    logic [1:0]  cmd_col = '0;
    logic        cmd_set = 1'b0;
    logic [2:0]  row_sel;
    logic [3:0]  col_sel;
    logic        wr_pol;
    logic        wr_en;
    logic        done;
    logic        err;
    logic [11:0] cfg_state;
    logic [11:0] cfg_known;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;

    xbar_cell_writer #(.ROWS(3), .COLS(4), .SETTLE_CYC(2), .PULSE_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_set(cmd_set),
        .row_sel(row_sel), .col_sel(col_sel), .wr_pol(wr_pol), .wr_en(wr_en),
        .done(done), .err(err), .cfg_state(cfg_state), .cfg_known(cfg_known)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse-width accounting and structural invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) wr_cnt++;
            if (wr_en && (row_sel == '0 || col_sel == '0))
                chk("wr_en_without_sel", 32'(row_sel), 32'h1);
            if (done && err)
                chk("done_err_overlap", 32'({done, err}), 32'h2);
        end
    end

    // Expected per-cycle outputs k cycles after a valid accept (S=2, P=4).
    task automatic chk_cycle(input string tag, input int k, input logic [2:0] rs, input logic [3:0] cs,
                             input logic pol);
        logic on;
        on = (k >= 1 && k <= 8);
        chk({tag, "_row_sel"}, 32'(row_sel), on ? 32'(rs) : 32'h0);
        chk({tag, "_col_sel"}, 32'(col_sel), on ? 32'(cs) : 32'h0);
        chk({tag, "_wr_en"}, 32'(wr_en), (k >= 3 && k <= 6) ? 32'h1 : 32'h0);
        chk({tag, "_done"}, 32'(done), (k == 9) ? 32'h1 : 32'h0);
        chk({tag, "_ready"}, 32'(cmd_ready), (k == 10) ? 32'h1 : 32'h0);
        if (on) chk({tag, "_wr_pol"}, 32'(wr_pol), 32'(pol));
    endtask

    initial begin
        logic [11:0] exp_state;
        logic [11:0] exp_known;
        int          wr_base;
        int          n_valid;
        int          r;
        int          c;
        logic        s;
        logic        bad;

        // Reset state
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_sels", 32'({row_sel, col_sel}), 32'h0);
        chk("rst_cfg", 32'({cfg_state, cfg_known}), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single SET of (row1, col2)
        cmd_valid = 1'b1; cmd_row = 2'd1; cmd_col = 2'd2; cmd_set = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk_cycle("single", k, 3'b010, 4'b0100, 1'b1);
            step();
        end
        chk("single_cfg_state", 32'(cfg_state), 32'h040);
        chk("single_cfg_known", 32'(cfg_known), 32'h040);

        // Back-to-back: SET (0,0) then RESET (1,2) with valid held high
        cmd_valid = 1'b1; cmd_row = 2'd0; cmd_col = 2'd0; cmd_set = 1'b1;
        step();
        cmd_row = 2'd1; cmd_col = 2'd2; cmd_set = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 10) chk_cycle("b2b_a", k, 3'b001, 4'b0001, 1'b1);
            else         chk_cycle("b2b_b", k - 10, 3'b010, 4'b0100, 1'b0);
            if (k == 11) cmd_valid = 1'b0;
            step();
        end
        chk("b2b_cfg_state", 32'(cfg_state), 32'h001);
        chk("b2b_cfg_known", 32'(cfg_known), 32'h041);

        // Out-of-range row is rejected
        cmd_valid = 1'b1; cmd_row = 2'd3; cmd_col = 2'd1; cmd_set = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("oor_err", 32'(err), 32'h1);
        chk("oor_ready", 32'(cmd_ready), 32'h1);
        chk("oor_sels", 32'({row_sel, col_sel}), 32'h0);
        chk("oor_wr_en", 32'(wr_en), 32'h0);
        chk("oor_done", 32'(done), 32'h0);
        step();
        chk("oor_err_clear", 32'(err), 32'h0);
        chk("oor_cfg", 32'({cfg_state, cfg_known}), 32'({12'h001, 12'h041}));

        // Inputs wiggling while busy must not disturb the write
        cmd_valid = 1'b1; cmd_row = 2'd2; cmd_col = 2'd3; cmd_set = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            chk_cycle("busy", k, 3'b100, 4'b1000, 1'b1);
            if (k <= 7) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_row   = 2'($urandom_range(0, 3));
                cmd_col   = 2'($urandom_range(0, 3));
                cmd_set   = 1'($urandom_range(0, 1));
            end else begin
                cmd_valid = 1'b0;
            end
            step();
        end
        chk("busy_cfg_state", 32'(cfg_state), 32'h801);
        chk("busy_cfg_known", 32'(cfg_known), 32'h841);

        // Reset in the middle of the write pulse
        cmd_valid = 1'b1; cmd_row = 2'd0; cmd_col = 2'd1; cmd_set = 1'b1;
        step();
        cmd_valid = 1'b0;
        step(); step(); step();
        chk("midrst_pre_wr_en", 32'(wr_en), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(wr_en), 32'h0);
        chk("midrst_ready", 32'(cmd_ready), 32'h1);
        chk("midrst_sels", 32'({row_sel, col_sel}), 32'h0);
        chk("midrst_cfg", 32'({cfg_state, cfg_known}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Random commands against a shadow model
        exp_state = '0;
        exp_known = '0;
        n_valid   = 0;
        wr_base   = wr_cnt;
        for (int n = 0; n < 200; n++) begin
            r   = int'($urandom_range(0, 3));
            c   = int'($urandom_range(0, 3));
            s   = 1'($urandom_range(0, 1));
            bad = (r >= 3);
            for (int w = 0; w < 50 && !cmd_ready; w++) step();
            cmd_valid = 1'b1; cmd_row = 2'(r); cmd_col = 2'(c); cmd_set = s;
            step();
            cmd_valid = 1'b0;
            for (int w = 0; w < 20 && !(done || err); w++) step();
            chk("rnd_resp", 32'({done, err}), bad ? 32'h1 : 32'h2);
            if (!bad) begin
                n_valid++;
                exp_state[r*4+c] = s;
                exp_known[r*4+c] = 1'b1;
            end
            step();
        end
        chk("rnd_cfg_state", 32'(cfg_state), 32'(exp_state));
        chk("rnd_cfg_known", 32'(cfg_known), 32'(exp_known));
        chk("rnd_wr_en_cycles", 32'(wr_cnt - wr_base), 32'(4 * n_valid));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
